// File: rtl/midi_status_pio_v2.sv
// Avalon-MM status PIO: R/W output register with set/clear aliases and synchronised inputs.
// Edge capture, IRQ mask and irq exist only when MIDI_PIO_EDGE_IRQ_EN is defined.
module midi_status_pio_v2 #(
  parameter int WIDTH       = 8,
  parameter int RESET_VALUE = 0,
  parameter int EDGE_MODE   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  localparam logic [31:0]      LP_RESET32 = 32'(RESET_VALUE);
  localparam logic [WIDTH-1:0] LP_RESET   = LP_RESET32[WIDTH-1:0];

  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] w_wd;
  logic [WIDTH-1:0] w_mask_rd;
  logic [WIDTH-1:0] w_cap_rd;
  logic             w_wr;
  logic             w_unused_ok;

  assign w_wr        = chipselect & ~write_n;
  assign w_wd        = writedata[WIDTH-1:0];
  assign w_unused_ok = &{1'b0, writedata};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out <= LP_RESET;
    end else if (w_wr) begin
      case (address)
        3'd0:    r_out <= w_wd;
        3'd4:    r_out <= r_out | w_wd;
        3'd5:    r_out <= r_out & ~w_wd;
        default: r_out <= r_out;
      endcase
    end
  end

  assign out_port = r_out;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

`ifdef MIDI_PIO_EDGE_IRQ_EN
  logic [WIDTH-1:0] r_hist;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_cap;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hist <= '0;
    end else begin
      r_hist <= r_sync2;
    end
  end

  always_comb begin
    w_edge = '0;
    case (EDGE_MODE)
      0:       w_edge = r_sync2 & ~r_hist;
      1:       w_edge = ~r_sync2 & r_hist;
      default: w_edge = r_sync2 ^ r_hist;
    endcase
  end

  assign w_clr = (w_wr && address == 3'd3) ? w_wd : '0;

  // A fresh edge overrides a same-cycle clear of that bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask <= '0;
      r_cap  <= '0;
    end else begin
      if (w_wr && address == 3'd2) begin
        r_mask <= w_wd;
      end
      r_cap <= (r_cap & ~w_clr) | w_edge;
    end
  end

  assign w_mask_rd = r_mask;
  assign w_cap_rd  = r_cap;
  assign irq       = |(r_cap & r_mask);
`else
  assign w_mask_rd = '0;
  assign w_cap_rd  = '0;
  assign irq       = 1'b0;
`endif

  always_comb begin
    readdata = '0;
    case (address)
      3'd0:    readdata[WIDTH-1:0] = r_out;
      3'd1:    readdata[WIDTH-1:0] = r_sync2;
      3'd2:    readdata[WIDTH-1:0] = w_mask_rd;
      3'd3:    readdata[WIDTH-1:0] = w_cap_rd;
      default: readdata = '0;
    endcase
  end

endmodule
